// File: rtl/board_state_ram_p_pkg.sv
`default_nettype none
// ============================================================================
// Module      : board_pkg
// Description : Shared cell/result codes, FSM state type and default board
//               dimensions for the ultimate-tic-tac-toe board store.
// Revision    : 1.0 - initial release
// ============================================================================
package board_pkg;

    // Cell contents and scoring results share one 2-bit encoding.
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;
    localparam logic [1:0] RES_DRAW   = 2'b11;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        EVAL_MACRO = 2'd1,
        EVAL_GAME  = 2'd2,
        CLEAR      = 2'd3
    } state_t;

    // Default board geometry (SIDE = 3).
    localparam int BOARD_SIDE = 3;
    localparam int N          = BOARD_SIDE * BOARD_SIDE;
    localparam int CNT_W      = $clog2(N * N);

endpackage

`default_nettype wire

// File: rtl/board_state_ram_p_line_checker.sv
`default_nettype none
// ============================================================================
// Module      : line_checker
// Description : Combinational scorer for one SIDE x SIDE grid of 2-bit codes.
//               Reports a win (01/10) when a full row, column or diagonal
//               holds one player code, 11 when every entry is non-zero with no
//               line, otherwise 00.
// Ports       : i_grid   - SIDE*SIDE entries, entry k at [2k+1:2k]
//               i_last   - code of the most recent writer (tie-break)
//               o_result - 00 open, 01 P1, 10 P2, 11 draw
// Revision    : 1.0 - initial release
// ============================================================================
module line_checker
    import board_pkg::*;
#(
    parameter int SIDE      = 3,
    parameter bit MASK_DRAW = 1'b0
) (
    input  logic [2*SIDE*SIDE-1:0] i_grid,
    input  logic [1:0]             i_last,
    output logic [1:0]             o_result
);

    localparam int c_CELLS = SIDE * SIDE;

    logic [2*c_CELLS-1:0] w_line_grid;
    logic                 w_full;
    logic                 w_p1_line;
    logic                 w_p2_line;

    // Drawn entries may not contribute to a line; fullness still counts them
    // as decided.
    generate
        for (genvar g = 0; g < c_CELLS; g++) begin : g_mask
            assign w_line_grid[2*g +: 2] =
                (MASK_DRAW && (i_grid[2*g +: 2] == RES_DRAW)) ? CELL_EMPTY
                                                               : i_grid[2*g +: 2];
        end
    endgenerate

    function automatic logic has_line(input logic [2*c_CELLS-1:0] grid,
                                      input logic [1:0]           code);
        logic found;
        logic all_r;
        logic all_c;
        logic diag0;
        logic diag1;
        found = 1'b0;
        diag0 = 1'b1;
        diag1 = 1'b1;
        for (int i = 0; i < SIDE; i++) begin
            all_r = 1'b1;
            all_c = 1'b1;
            for (int j = 0; j < SIDE; j++) begin
                all_r = all_r & (grid[2*(i*SIDE+j) +: 2] == code);
                all_c = all_c & (grid[2*(j*SIDE+i) +: 2] == code);
            end
            found = found | all_r | all_c;
            diag0 = diag0 & (grid[2*(i*SIDE+i) +: 2] == code);
            diag1 = diag1 & (grid[2*(i*SIDE+(SIDE-1-i)) +: 2] == code);
        end
        return found | diag0 | diag1;
    endfunction

    always_comb begin
        o_result = CELL_EMPTY;
        w_full   = 1'b1;
        for (int i = 0; i < c_CELLS; i++) begin
            w_full = w_full & (i_grid[2*i +: 2] != CELL_EMPTY);
        end
        w_p1_line = has_line(w_line_grid, CELL_P1);
        w_p2_line = has_line(w_line_grid, CELL_P2);
        // Only the latest writer can have just completed a line.
        if (w_p1_line && w_p2_line) begin
            o_result = i_last;
        end else if (w_p1_line) begin
            o_result = CELL_P1;
        end else if (w_p2_line) begin
            o_result = CELL_P2;
        end else if (w_full) begin
            o_result = RES_DRAW;
        end
    end

endmodule

`default_nettype wire

// File: rtl/board_state_ram_p.sv
`default_nettype none
// ============================================================================
// Module      : board_state_ram_p
// Description : Ultimate-tic-tac-toe board store. Validates and stores moves,
//               re-scores the touched macro board and then the global board,
//               and clears the whole board with a one-cell-per-cycle sweep.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               wr_en/wr_macro/wr_micro/wr_player - move request
//               wr_ack/wr_nack             - registered move response
//               rd_macro/rd_micro/rd_data  - 1-cycle-latency cell read
//               clear                      - start full-board clear
//               busy/eval_done             - status
//               macro_state/game_state     - scoring results
// Revision    : 1.0 - initial release
// ============================================================================
module board_state_ram_p
    import board_pkg::*;
#(
    parameter int SIDE      = 3,
    parameter int ADDR_W    = 4,
    parameter bit GLOBAL_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_macro,
    input  logic [ADDR_W-1:0]      wr_micro,
    input  logic [1:0]             wr_player,
    output logic                   wr_ack,
    output logic                   wr_nack,
    input  logic [ADDR_W-1:0]      rd_macro,
    input  logic [ADDR_W-1:0]      rd_micro,
    output logic [1:0]             rd_data,
    input  logic                   clear,
    output logic                   busy,
    output logic                   eval_done,
    output logic [2*SIDE*SIDE-1:0] macro_state,
    output logic [1:0]             game_state
);

    localparam int c_CELLS = SIDE * SIDE;
    localparam int c_TOTAL = c_CELLS * c_CELLS;
    localparam int c_IDX_W = $clog2(c_TOTAL);

    state_t               r_state;
    state_t               w_next_state;
    logic [1:0]           r_cells [c_TOTAL];
    logic [c_IDX_W-1:0]   r_clr_cnt;
    logic [ADDR_W-1:0]    r_mac_idx;      // zero-based macro under evaluation
    logic [1:0]           r_last_player;
    logic [2*c_CELLS-1:0] r_mres;
    logic [1:0]           r_game;
    logic [1:0]           r_rd_data;
    logic                 r_wr_ack;
    logic                 r_wr_nack;
    logic                 r_eval_done;

    logic [c_IDX_W-1:0]   w_wr_idx;
    logic [c_IDX_W-1:0]   w_rd_idx;
    logic [c_IDX_W-1:0]   w_base;
    logic [1:0]           w_sel_mres;
    logic                 w_accept;
    logic [2*c_CELLS-1:0] w_macro_grid;
    logic [1:0]           w_macro_res;
    logic [1:0]           w_game_res;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a != '0) && (int'(a) <= c_CELLS);
    endfunction

    function automatic logic [c_IDX_W-1:0] cell_idx(input logic [ADDR_W-1:0] m,
                                                   input logic [ADDR_W-1:0] mi);
        return c_IDX_W'((int'(m) - 1) * c_CELLS + (int'(mi) - 1));
    endfunction

    assign w_wr_idx = cell_idx(wr_macro, wr_micro);
    assign w_rd_idx = cell_idx(rd_macro, rd_micro);
    assign w_base   = c_IDX_W'(int'(r_mac_idx) * c_CELLS);

    // Current result of the addressed macro, 00 for an invalid address.
    always_comb begin
        w_sel_mres = CELL_EMPTY;
        for (int k = 0; k < c_CELLS; k++) begin
            if (int'(wr_macro) == k + 1) begin
                w_sel_mres = r_mres[2*k +: 2];
            end
        end
    end

    // Out-of-range indices only arise with invalid addresses, which are
    // already excluded by addr_ok.
    assign w_accept = wr_en && (r_state == IDLE) && !clear &&
                      addr_ok(wr_macro) && addr_ok(wr_micro) &&
                      ((wr_player == CELL_P1) || (wr_player == CELL_P2)) &&
                      (r_cells[w_wr_idx] == CELL_EMPTY) &&
                      (w_sel_mres == CELL_EMPTY) &&
                      (r_game == CELL_EMPTY);

    always_comb begin
        w_macro_grid = '0;
        for (int j = 0; j < c_CELLS; j++) begin
            w_macro_grid[2*j +: 2] = r_cells[w_base + c_IDX_W'(j)];
        end
    end

    line_checker #(.SIDE(SIDE), .MASK_DRAW(1'b0)) u_macro_chk (
        .i_grid   (w_macro_grid),
        .i_last   (r_last_player),
        .o_result (w_macro_res)
    );

    generate
        if (GLOBAL_EN) begin : g_global
            line_checker #(.SIDE(SIDE), .MASK_DRAW(1'b1)) u_game_chk (
                .i_grid   (r_mres),
                .i_last   (r_last_player),
                .o_result (w_game_res)
            );
        end else begin : g_no_global
            assign w_game_res = CELL_EMPTY;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (clear) begin
                    w_next_state = CLEAR;
                end else if (w_accept) begin
                    w_next_state = EVAL_MACRO;
                end
            end
            EVAL_MACRO: w_next_state = EVAL_GAME;
            EVAL_GAME:  w_next_state = IDLE;
            CLEAR: begin
                if (r_clr_cnt == c_IDX_W'(c_TOTAL - 1)) begin
                    w_next_state = IDLE;
                end
            end
            default:    w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_TOTAL; i++) begin
                r_cells[i] <= CELL_EMPTY;
            end
            r_clr_cnt     <= '0;
            r_mac_idx     <= '0;
            r_last_player <= CELL_EMPTY;
            r_mres        <= '0;
            r_game        <= CELL_EMPTY;
            r_rd_data     <= CELL_EMPTY;
            r_wr_ack      <= 1'b0;
            r_wr_nack     <= 1'b0;
            r_eval_done   <= 1'b0;
        end else begin
            r_wr_ack    <= w_accept;
            r_wr_nack   <= wr_en && !w_accept;
            r_eval_done <= (r_state == EVAL_GAME);
            // Non-blocking read returns the pre-write value on a collision.
            r_rd_data   <= (addr_ok(rd_macro) && addr_ok(rd_micro)) ?
                           r_cells[w_rd_idx] : CELL_EMPTY;
            case (r_state)
                IDLE: begin
                    if (clear) begin
                        r_clr_cnt <= '0;
                    end else if (w_accept) begin
                        r_cells[w_wr_idx] <= wr_player;
                        r_mac_idx         <= wr_macro - ADDR_W'(1);
                        r_last_player     <= wr_player;
                    end
                end
                EVAL_MACRO: begin
                    for (int k = 0; k < c_CELLS; k++) begin
                        if (r_mac_idx == ADDR_W'(k)) begin
                            r_mres[2*k +: 2] <= w_macro_res;
                        end
                    end
                end
                EVAL_GAME: begin
                    r_game <= w_game_res;
                end
                CLEAR: begin
                    r_cells[r_clr_cnt] <= CELL_EMPTY;
                    r_clr_cnt          <= r_clr_cnt + c_IDX_W'(1);
                    if (r_clr_cnt == '0) begin
                        r_mres <= '0;
                        r_game <= CELL_EMPTY;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != IDLE);
    assign wr_ack      = r_wr_ack;
    assign wr_nack     = r_wr_nack;
    assign rd_data     = r_rd_data;
    assign eval_done   = r_eval_done;
    assign macro_state = r_mres;
    assign game_state  = r_game;

endmodule

`default_nettype wire

// File: tb/tb_board_state_ram_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_state_ram_p
// Description : Directed self-checking bench for board_state_ram_p (SIDE=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_state_ram_p;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_macro;
    logic [3:0]  wr_micro;
    logic [1:0]  wr_player;
    logic        wr_ack;
    logic        wr_nack;
    logic [3:0]  rd_macro;
    logic [3:0]  rd_micro;
    logic [1:0]  rd_data;
    logic        clear;
    logic        busy;
    logic        eval_done;
    logic [17:0] macro_state;
    logic [1:0]  game_state;

    int checks   = 0;
    int failures = 0;

    board_state_ram_p #(.SIDE(3), .ADDR_W(4), .GLOBAL_EN(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_macro    (wr_macro),
        .wr_micro    (wr_micro),
        .wr_player   (wr_player),
        .wr_ack      (wr_ack),
        .wr_nack     (wr_nack),
        .rd_macro    (rd_macro),
        .rd_micro    (rd_micro),
        .rd_data     (rd_data),
        .clear       (clear),
        .busy        (busy),
        .eval_done   (eval_done),
        .macro_state (macro_state),
        .game_state  (game_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one move; returns response and, for accepted moves, eval_done
    // sampled two cycles after the ack cycle.
    task automatic move(input logic [3:0] m, input logic [3:0] mi, input logic [1:0] p,
                        output logic ack, output logic nack, output logic done);
        wr_macro  = m;
        wr_micro  = mi;
        wr_player = p;
        wr_en     = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
        ack   = wr_ack;
        nack  = wr_nack;
        done  = 1'b0;
        if (ack) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            done = eval_done;
        end
    endtask

    task automatic read_cell(input logic [3:0] m, input logic [3:0] mi, output logic [1:0] d);
        rd_macro = m;
        rd_micro = mi;
        @(posedge clk); #1;
        d = rd_data;
    endtask

    task automatic test_reset;
        logic [1:0] d;
        rst_n = 1'b0; wr_en = 1'b0; clear = 1'b0;
        wr_macro = '0; wr_micro = '0; wr_player = '0; rd_macro = 4'd1; rd_micro = 4'd1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (macro_state !== 18'd0) begin failures++; $display("FAIL reset_macro_state got=%h exp=0", macro_state); end
        checks++;
        if (game_state !== 2'b00) begin failures++; $display("FAIL reset_game_state got=%b exp=00", game_state); end
        checks++;
        if ({busy, eval_done, wr_ack, wr_nack, rd_data} !== 6'd0) begin
            failures++; $display("FAIL reset_outputs got=%b exp=000000", {busy, eval_done, wr_ack, wr_nack, rd_data});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int m = 1; m <= 9; m++) begin
            for (int mi = 1; mi <= 9; mi++) begin
                read_cell(4'(m), 4'(mi), d);
                checks++;
                if (d !== 2'b00) begin failures++; $display("FAIL reset_cell m=%0d c=%0d got=%b exp=00", m, mi, d); end
            end
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_macro_win;
        logic [3:0] cells [5] = '{4'd1, 4'd2, 4'd5, 4'd3, 4'd9};
        logic [1:0] plrs  [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        logic ack, nack, done;
        logic [1:0] d;
        for (int i = 0; i < 5; i++) begin
            move(4'd1, cells[i], plrs[i], ack, nack, done);
            checks++;
            if (ack !== 1'b1 || nack !== 1'b0) begin
                failures++; $display("FAIL win_ack move=%0d got ack=%b nack=%b exp ack=1 nack=0", i, ack, nack);
            end
            checks++;
            if (done !== 1'b1) begin failures++; $display("FAIL win_eval_done move=%0d got=%b exp=1", i, done); end
            checks++;
            if (macro_state[1:0] !== ((i == 4) ? 2'b01 : 2'b00)) begin
                failures++; $display("FAIL win_macro1 move=%0d got=%b exp=%b", i, macro_state[1:0], (i == 4) ? 2'b01 : 2'b00);
            end
        end
        checks++;
        if (game_state !== 2'b00) begin failures++; $display("FAIL win_game got=%b exp=00", game_state); end
        read_cell(4'd1, 4'd5, d);
        checks++;
        if (d !== 2'b01) begin failures++; $display("FAIL win_read_1_5 got=%b exp=01", d); end
        read_cell(4'd1, 4'd3, d);
        checks++;
        if (d !== 2'b10) begin failures++; $display("FAIL win_read_1_3 got=%b exp=10", d); end
    endtask

    task automatic test_illegal;
        logic [3:0] ms  [8] = '{4'd1, 4'd1, 4'd0, 4'd10, 4'd2, 4'd2, 4'd2, 4'd2};
        logic [3:0] mis [8] = '{4'd5, 4'd4, 4'd1, 4'd1,  4'd0, 4'd10, 4'd1, 4'd1};
        logic [1:0] ps  [8] = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b00};
        logic ack, nack, done;
        logic [1:0] d;
        for (int i = 0; i < 8; i++) begin
            move(ms[i], mis[i], ps[i], ack, nack, done);
            checks++;
            if (ack !== 1'b0 || nack !== 1'b1) begin
                failures++; $display("FAIL illegal_nack case=%0d got ack=%b nack=%b exp ack=0 nack=1", i, ack, nack);
            end
        end
        // Occupied cell in an undecided macro.
        move(4'd3, 4'd1, 2'b01, ack, nack, done);
        checks++;
        if (ack !== 1'b1 || nack !== 1'b0) begin failures++; $display("FAIL occupied_first got ack=%b nack=%b exp ack=1 nack=0", ack, nack); end
        move(4'd3, 4'd1, 2'b10, ack, nack, done);
        checks++;
        if (ack !== 1'b0 || nack !== 1'b1) begin failures++; $display("FAIL occupied_second got ack=%b nack=%b exp ack=0 nack=1", ack, nack); end
        read_cell(4'd1, 4'd5, d);
        checks++;
        if (d !== 2'b01) begin failures++; $display("FAIL illegal_cell_1_5 got=%b exp=01", d); end
        read_cell(4'd3, 4'd1, d);
        checks++;
        if (d !== 2'b01) begin failures++; $display("FAIL illegal_cell_3_1 got=%b exp=01", d); end
        read_cell(4'd2, 4'd1, d);
        checks++;
        if (d !== 2'b00) begin failures++; $display("FAIL illegal_cell_2_1 got=%b exp=00", d); end
        read_cell(4'd0, 4'd1, d);
        checks++;
        if (d !== 2'b00) begin failures++; $display("FAIL read_addr0 got=%b exp=00", d); end
        read_cell(4'd10, 4'd1, d);
        checks++;
        if (d !== 2'b00) begin failures++; $display("FAIL read_addr10 got=%b exp=00", d); end
        checks++;
        if (macro_state !== 18'h00001) begin failures++; $display("FAIL illegal_macro_state got=%h exp=00001", macro_state); end
    endtask

    task automatic test_draw_macro;
        logic [3:0] cells [9] = '{4'd1, 4'd3, 4'd2, 4'd4, 4'd6, 4'd5, 4'd7, 4'd8, 4'd9};
        logic [1:0] plrs  [9] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        logic ack, nack, done;
        for (int i = 0; i < 9; i++) begin
            move(4'd2, cells[i], plrs[i], ack, nack, done);
            checks++;
            if (ack !== 1'b1) begin failures++; $display("FAIL draw_ack move=%0d got=%b exp=1", i, ack); end
            if (i == 7) begin
                checks++;
                if (macro_state[3:2] !== 2'b00) begin failures++; $display("FAIL draw_pre got=%b exp=00", macro_state[3:2]); end
            end
        end
        checks++;
        if (macro_state[3:2] !== 2'b11) begin failures++; $display("FAIL draw_macro2 got=%b exp=11", macro_state[3:2]); end
        move(4'd3, 4'd2, 2'b01, ack, nack, done);
        move(4'd3, 4'd3, 2'b01, ack, nack, done);
        checks++;
        if (macro_state[5:0] !== 6'b01_11_01) begin failures++; $display("FAIL row_macros got=%b exp=011101", macro_state[5:0]); end
        checks++;
        if (game_state !== 2'b00) begin failures++; $display("FAIL draw_no_global got=%b exp=00", game_state); end
    endtask

    task automatic test_game_win;
        logic ack, nack, done;
        for (int i = 1; i <= 3; i++) move(4'd5, 4'(i), 2'b01, ack, nack, done);
        checks++;
        if (macro_state[9:8] !== 2'b01 || game_state !== 2'b00) begin
            failures++; $display("FAIL game_mid got m5=%b game=%b exp m5=01 game=00", macro_state[9:8], game_state);
        end
        for (int i = 1; i <= 3; i++) move(4'd9, 4'(i), 2'b01, ack, nack, done);
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL game_eval_done got=%b exp=1", done); end
        checks++;
        if (game_state !== 2'b01) begin failures++; $display("FAIL game_state got=%b exp=01", game_state); end
        checks++;
        if (macro_state !== 18'h1011D) begin failures++; $display("FAIL game_macro_state got=%h exp=1011d", macro_state); end
        move(4'd4, 4'd1, 2'b10, ack, nack, done);
        checks++;
        if (ack !== 1'b0 || nack !== 1'b1) begin failures++; $display("FAIL over_nack_a got ack=%b nack=%b exp ack=0 nack=1", ack, nack); end
        move(4'd6, 4'd5, 2'b01, ack, nack, done);
        checks++;
        if (ack !== 1'b0 || nack !== 1'b1) begin failures++; $display("FAIL over_nack_b got ack=%b nack=%b exp ack=0 nack=1", ack, nack); end
    endtask

    task automatic test_clear;
        int n;
        logic [1:0] d;
        logic ack, nack, done;
        n = 0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        while (busy && n < 200) begin
            if (n == 2) begin
                checks++;
                if (macro_state !== 18'd0 || game_state !== 2'b00) begin
                    failures++; $display("FAIL clear_results got m=%h g=%b exp 0", macro_state, game_state);
                end
            end
            if (n == 3) begin
                wr_macro = 4'd4; wr_micro = 4'd1; wr_player = 2'b01; wr_en = 1'b1;
            end else begin
                wr_en = 1'b0;
            end
            if (n == 4) begin
                checks++;
                if (wr_nack !== 1'b1 || wr_ack !== 1'b0) begin
                    failures++; $display("FAIL busy_move got ack=%b nack=%b exp ack=0 nack=1", wr_ack, wr_nack);
                end
            end
            if (n == 5) begin rd_macro = 4'd9; rd_micro = 4'd1; end
            if (n == 6) begin
                checks++;
                if (rd_data !== 2'b01) begin failures++; $display("FAIL clear_partial_read got=%b exp=01", rd_data); end
            end
            n++;
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        checks++;
        if (n != 81) begin failures++; $display("FAIL clear_busy_cycles got=%0d exp=81", n); end
        for (int m = 1; m <= 9; m++) begin
            for (int mi = 1; mi <= 9; mi++) begin
                read_cell(4'(m), 4'(mi), d);
                checks++;
                if (d !== 2'b00) begin failures++; $display("FAIL cleared_cell m=%0d c=%0d got=%b exp=00", m, mi, d); end
            end
        end
        move(4'd1, 4'd1, 2'b01, ack, nack, done);
        checks++;
        if (ack !== 1'b1) begin failures++; $display("FAIL post_clear_move got=%b exp=1", ack); end
    endtask

    task automatic test_reset_mid_clear;
        logic ack, nack, done;
        logic [1:0] d;
        move(4'd9, 4'd9, 2'b10, ack, nack, done);
        read_cell(4'd9, 4'd9, d);
        checks++;
        if (d !== 2'b10) begin failures++; $display("FAIL pre_reset_cell got=%b exp=10", d); end
        // clear wins over a same-cycle legal move
        clear = 1'b1; wr_en = 1'b1; wr_macro = 4'd4; wr_micro = 4'd4; wr_player = 2'b01;
        @(posedge clk); #1;
        clear = 1'b0; wr_en = 1'b0;
        checks++;
        if (wr_nack !== 1'b1 || wr_ack !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL clear_priority got ack=%b nack=%b busy=%b exp ack=0 nack=1 busy=1", wr_ack, wr_nack, busy);
        end
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || macro_state !== 18'd0 || game_state !== 2'b00) begin
            failures++; $display("FAIL mid_clear_reset got busy=%b m=%h g=%b exp 0", busy, macro_state, game_state);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int m = 1; m <= 9; m++) begin
            for (int mi = 1; mi <= 9; mi++) begin
                read_cell(4'(m), 4'(mi), d);
                checks++;
                if (d !== 2'b00) begin failures++; $display("FAIL reset_clear_cell m=%0d c=%0d got=%b exp=00", m, mi, d); end
            end
        end
        move(4'd5, 4'd5, 2'b01, ack, nack, done);
        checks++;
        if (ack !== 1'b1 || done !== 1'b1) begin failures++; $display("FAIL post_reset_move got ack=%b done=%b exp 1 1", ack, done); end
    endtask

    initial begin
        test_reset();
        test_macro_win();
        test_illegal();
        test_draw_macro();
        test_game_win();
        test_clear();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
